seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. It latches a packed hex value on a load strobe and scans one digit per slot with inter-digit blanking. It also provides optional leading-zero suppression and per-digit blinking. The block sits between the datapath's display register and the board pins, and replaces per-digit static decoders.

## Interface
- `DIGITS`, 8: number of digits scanned; legal range 1..16.
- `SCAN_DIV`, 1000: clock cycles per digit slot; must be ≥ `BLANK_CYCLES`+1.
- `BLANK_CYCLES`, 2: cycles at the start of each slot with all anodes off (anti-ghosting); may be 0.
- `BLINK_FRAMES`, 64: full scans per blink half-period; must be ≥ 1.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: one-cycle strobe; latch `value`/`dp_in` into the shadow register.
- `value` in 4*DIGITS: packed hex digits; digit i = `value[4i+3:4i]`, and digit 0 is the rightmost.
- `dp_in` in DIGITS: decimal point per digit, 1 = lit.
- `lz_en` in 1: 1 = suppress leading zeros (sampled live, not shadowed).
- `blink_mask` in DIGITS: 1 = digit i blinks (sampled live).
- `an` out DIGITS: digit enables, active low, one-hot-low or all-high.
- `seg` out 7: segments a..g on bits 6..0, active low.
- `dp` out 1: decimal point, active low.
- `frame_tick` out 1: one-cycle pulse at each scan wrap.

## Operation
- Shadow register: `shadow_val`/`shadow_dp` are loaded at the edge where `load`=1. They hold their contents otherwise. Reset value is 0.
- Prescaler `pcnt` counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and digit index `idx` (width clog2(DIGITS), minimum 1) advances. `idx` wraps from DIGITS-1 to 0.
- `frame_tick`=1 for the single cycle after `idx` wraps to 0. It is not asserted after reset.
- Decode table, active low, bits a..g:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Leading-zero suppression: digit i is suppressed when `lz_en`=1, i>0, and shadow digits i..DIGITS-1 are all zero. When suppressed, `seg`=1111111. `dp` still follows `shadow_dp[i]`.
- Blank slot: while `pcnt` < BLANK_CYCLES, `an`, `seg` and `dp` are all high.
- Active slot: `an[idx]`=0 and all other anode bits are 1. `seg`/`dp` show digit `idx`.
- Boundary cases:
  - `load` asserted every cycle: the shadow register tracks `value` continuously.
  - `load` coincident with a slot boundary: the new slot shows the old shadow for one cycle, then the new value.
  - DIGITS=1: `idx` stays 0, and `frame_tick` pulses on every `pcnt` wrap.
  - `rst` mid-slot: every output returns to its reset value on the next edge.

## Timing
- Reset values:
  - `an` = all 1s, `seg`=1111111, `dp`=1, `frame_tick`=0.
  - `pcnt`=0, `idx`=0, shadow=0, blink phase=0.
- `an`/`seg`/`dp` are registered, one cycle after the `pcnt`/`idx` state they reflect. The first active output is at cycle BLANK_CYCLES+1 after reset release.
- Load latency: `load` sampled at edge N. The value is in shadow after edge N and visible on `seg` from edge N+1, provided the slot is active.
- `lz_en`/`blink_mask` changes are visible on the next registered output.
- Full scan period = DIGITS×SCAN_DIV cycles.

## Configuration
- Macro: `SEGSCAN_BLINK_EN`.
- Defined:
  - A blink-phase counter counts `frame_tick` pulses. It toggles phase every BLINK_FRAMES ticks and resets to phase 0.
  - While phase=1, digits with `blink_mask[i]`=1 output `seg`=1111111 and `dp`=1. `an` is unaffected.
- Undefined:
  - The counter and phase logic are absent.
  - `blink_mask` is ignored, but the port remains.
  - Output is identical to the defined case with phase held at 0.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2.
- **Reset/scan:** release `rst` → `an`=1111 for 2 cycles, then 1110 for 3 cycles. Sequence 1110, 1101, 1011, 0111 repeats every 16 cycles. `frame_tick` pulses once per 16 cycles.
- **Decode:** load 0x4C8F, `dp_in`=0010 → `seg` per slot: 0111000 (F), 0000000 (8), 0110001 (C), 1001100 (4). `dp`=0 only on digit 1.
- **Leading zeros:** load 0x0070, `lz_en`=1 → digits 3,2 `seg`=1111111; digit 1=0001111; digit 0=0000001. With `lz_en`=0 → digits 3,2 show 0000001. Load 0x0000 with `lz_en`=1 → only digit 0 shows 0000001.
- **Load timing:** load 0x1111, then 0x2222 mid-slot → `seg` changes 1001111→0010010 exactly 1 cycle after the second load edge. There is no change on the blank cycle.
- **Blink** (`SEGSCAN_BLINK_EN` on): `blink_mask`=0001, 0x1234 → digit 0 shows 1001100 for 2 frames, then 1111111 for 2 frames. `an` pattern is unchanged. With the macro off, digit 0 stays 1001100.
- **Reset mid-slot:** assert `rst` for 1 cycle while `an`=1011 → next edge `an`=1111, `seg`=1111111, shadow cleared. The scan restarts as in the first scenario.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a bank of common-anode
// seven-segment digits. Latches a packed hex value on a load strobe, scans
// one digit per slot with a short all-off blanking window at the start of
// each slot, and optionally suppresses leading zeros.
// Optional feature macro: SEGSCAN_BLINK_EN enables per-digit blinking
// driven by a frame-counting blink phase. Without it blink_mask is ignored.
module seg_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int NSLOT  = 1 << IDX_W;

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                frame_tick_q, frame_tick_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic                pcnt_wrap;
  logic                blink_phase;

  // Digit-indexed views padded to a power of two so idx can index directly.
  logic [4*NSLOT-1:0]  val_wide;
  logic [3:0]          digit_arr [NSLOT];
  logic [NSLOT-1:0]    upper_zero;
  logic [NSLOT-1:0]    dp_wide;
  logic [NSLOT-1:0]    mask_wide;
  logic [NSLOT-1:0]    an_wide;

  function automatic logic [6:0] decode_hex(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Prescaler and digit index: advance the slot at each prescaler wrap.
  always_comb begin
    pcnt_wrap    = (pcnt_q == PCNT_LAST);
    pcnt_d       = pcnt_wrap ? '0 : pcnt_q + 1'b1;
    idx_d        = idx_q;
    frame_tick_d = 1'b0;
    if (pcnt_wrap) begin
      if (idx_q == IDX_LAST) begin
        idx_d        = '0;
        frame_tick_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Shadow register captures the display value only on the load strobe.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
    end
  end

  // Flag each digit whose position and everything above it hold zero.
  always_comb begin
    logic acc;
    val_wide = (4*NSLOT)'(shadow_val_q);
    acc      = 1'b1;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      digit_arr[i]  = val_wide[4*i +: 4];
      acc           = acc & (digit_arr[i] == 4'h0);
      upper_zero[i] = acc;
    end
  end

`ifdef SEGSCAN_BLINK_EN
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);

  logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;

  // Count completed frames and flip the blink phase every BLINK_FRAMES.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_tick_q) begin
      if (blink_cnt_q == BC_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Blink counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_phase = blink_phase_q;
`else
  assign blink_phase = 1'b0;
`endif

  // Output decode: blank window, then the selected digit with suppression.
  always_comb begin
    logic suppress;
    logic blink_off;
    dp_wide   = NSLOT'(shadow_dp_q);
    mask_wide = NSLOT'(blink_mask);
    an_wide   = '1;
    an_d      = '1;
    seg_d     = 7'b1111111;
    dp_d      = 1'b1;
    suppress  = lz_en && (idx_q != '0) && upper_zero[idx_q];
    blink_off = blink_phase && mask_wide[idx_q];
    if (int'(pcnt_q) >= BLANK_CYCLES) begin
      an_wide[idx_q] = 1'b0;
      an_d           = an_wide[DIGITS-1:0];
      if (!blink_off) begin
        seg_d = suppress ? 7'b1111111 : decode_hex(digit_arr[idx_q]);
        dp_d  = ~dp_wide[idx_q];
      end
    end
  end

  // Core state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      frame_tick_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver with a 4-digit,
// fast-scan configuration. A cycle model pushes the expected registered
// outputs at each rising edge; they are popped and compared at the falling
// edge. Honours SEGSCAN_BLINK_EN the same way the design does.
module tb_seg_scan_driver;

   localparam int DIGITS       = 4;
   localparam int SCAN_DIV     = 4;
   localparam int BLANK_CYCLES = 1;
   localparam int BLINK_FRAMES = 2;
   localparam int FRAME        = DIGITS * SCAN_DIV;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       ft;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dpIn;
   logic        lzEn;
   logic [3:0]  blinkMask;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frameTick;

   exp_t        expQ[$];
   int          assertCount = 0;
   int          failCount   = 0;

   int unsigned tick;
   logic [15:0] shVal;
   logic [3:0]  shDp;

   logic [6:0]  segTable [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   seg_scan_driver #(
      .DIGITS(DIGITS),
      .SCAN_DIV(SCAN_DIV),
      .BLANK_CYCLES(BLANK_CYCLES),
      .BLINK_FRAMES(BLINK_FRAMES)
   ) dut (
      .clk(clock),
      .rst(reset),
      .load(load),
      .value(value),
      .dp_in(dpIn),
      .lz_en(lzEn),
      .blink_mask(blinkMask),
      .an(an),
      .seg(seg),
      .dp(dp),
      .frame_tick(frameTick)
   );

   // Free-running clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Counts a comparison and reports it when the observed value differs.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Reference model: expected outputs for this edge from the time since reset.
   always @(posedge clock) begin
      exp_t        e;
      int unsigned pos, slot, frames;
      bit          phase, supp;
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.ft  = 1'b0;
      if (reset) begin
         tick  = 0;
         shVal = 16'h0;
         shDp  = 4'h0;
      end else begin
         pos    = tick % SCAN_DIV;
         slot   = (tick / SCAN_DIV) % DIGITS;
         frames = (tick == 0) ? 0 : (tick - 1) / FRAME;
`ifdef SEGSCAN_BLINK_EN
         phase  = ((frames / BLINK_FRAMES) % 2) == 1;
`else
         phase  = 1'b0;
`endif
         supp   = lzEn && (slot > 0) && ((shVal >> (4 * slot)) == 16'h0);
         e.ft   = (tick % FRAME) == FRAME - 1;
         if (pos >= BLANK_CYCLES) begin
            e.an       = 4'hF;
            e.an[slot] = 1'b0;
            if (!(phase && blinkMask[slot])) begin
               e.seg = supp ? 7'h7F : segTable[shVal[4*slot +: 4]];
               e.dp  = ~shDp[slot];
            end
         end
         if (load) begin
            shVal = value;
            shDp  = dpIn;
         end
         tick++;
      end
      expQ.push_back(e);
   end

   // Scoreboard drain: compare DUT outputs away from the rising edge.
   always @(negedge clock) begin
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("an", 32'(an), 32'(e.an));
         checkOutput("seg", 32'(seg), 32'(e.seg));
         checkOutput("dp", 32'(dp), 32'(e.dp));
         checkOutput("frame_tick", 32'(frameTick), 32'(e.ft));
      end
   end

   // Drives one load (or idle) cycle followed by idle cycles.
   task automatic applyStimulus(input logic ld, input logic [15:0] val, input logic [3:0] dpv, input int cycles);
      @(negedge clock);
      load  = ld;
      value = val;
      dpIn  = dpv;
      @(negedge clock);
      load = 1'b0;
      repeat (cycles - 1) @(negedge clock);
   endtask

   // Waits, with a bound, until the next edge lands on the given slot position.
   task automatic waitSlot(input int unsigned slot, input int unsigned pos);
      logic found;
      found = 1'b0;
      for (int n = 0; n < 4 * FRAME && !found; n++) begin
         @(negedge clock);
         if ((tick % SCAN_DIV) == pos && ((tick / SCAN_DIV) % DIGITS) == slot)
            found = 1'b1;
      end
      checkOutput("waitSlot", 32'(found), 32'd1);
   endtask

   // Stimulus sequence.
   initial begin
      reset     = 1'b1;
      load      = 1'b0;
      value     = 16'h0;
      dpIn      = 4'h0;
      lzEn      = 1'b0;
      blinkMask = 4'h0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      $display("[TB] reset released, scanning zeros");
      repeat (20) @(negedge clock);

      $display("[TB] decode 0x4C8F");
      applyStimulus(1'b1, 16'h4C8F, 4'b0010, 20);

      $display("[TB] leading zeros");
      lzEn = 1'b1;
      applyStimulus(1'b1, 16'h0070, 4'b0000, 20);
      lzEn = 1'b0;
      repeat (20) @(negedge clock);
      lzEn = 1'b1;
      applyStimulus(1'b1, 16'h0000, 4'b0000, 20);
      lzEn = 1'b0;

      $display("[TB] load timing");
      waitSlot(1, 1);
      load  = 1'b1;
      value = 16'h1111;
      dpIn  = 4'h0;
      @(negedge clock);
      load = 1'b0;
      applyStimulus(1'b1, 16'h2222, 4'b0000, 20);

      $display("[TB] blink");
      blinkMask = 4'b0001;
      applyStimulus(1'b1, 16'h1234, 4'b0000, 5 * FRAME);
      blinkMask = 4'b0000;

      $display("[TB] reset mid-slot");
      waitSlot(2, 2);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      repeat (24) @(negedge clock);

      $display("[TB] load every cycle");
      for (int i = 0; i < 12; i++) begin
         load  = 1'b1;
         value = 16'($urandom);
         dpIn  = 4'($urandom);
         @(negedge clock);
      end
      load = 1'b0;
      repeat (8) @(negedge clock);

      @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
